// File: rtl/flag_period_monitor_pkg.sv
// Shared types and defaults for the flag period monitor.
//   state_t      : FSM encoding (IDLE / ACQ / LOCKED)
//   DEF_*        : default parameter values for the top and the interface
//   ERR_CNT_W    : width of the saturating error counter
//   sat_inc_err  : saturating increment for the error counter
package flag_period_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_DIV      = 6;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TIMEOUT  = 24;
  localparam int DEF_CNT_W    = 8;
  localparam int ERR_CNT_W    = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/flag_period_monitor_if.sv
// Strobe-in / status-out bundle of the flag period monitor.
//   flag_in    : one-cycle strobe from the divider
//   period     : last measured strobe-to-strobe interval
//   period_vld : one-cycle pulse, period updated
//   locked     : high while the monitor is locked
//   err_pulse  : one-cycle pulse, wrong period while locked
//   timeout    : one-cycle pulse, strobe missing too long
//   err_cnt    : saturating error count
// master drives the strobe and observes status; slave is the monitor.
interface flag_period_monitor_if
  import flag_period_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic                 flag_in;
  logic [CNT_W-1:0]     period;
  logic                 period_vld;
  logic                 locked;
  logic                 err_pulse;
  logic                 timeout;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output flag_in,
    input  period, period_vld, locked, err_pulse, timeout, err_cnt
  );

  modport slave (
    input  flag_in,
    output period, period_vld, locked, err_pulse, timeout, err_cnt
  );

endinterface

// File: rtl/flag_period_monitor_interval_cnt.sv
// Interval counter: cleared by each strobe, otherwise counts up and
// saturates at all-ones so a long-missing strobe can never wrap.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   i_clr : synchronous clear (the strobe)
//   o_cnt : cycles since the last strobe, minus one
module flag_interval_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/flag_period_monitor.sv
// Flag period monitor: measures strobe-to-strobe intervals, compares them
// with DIV and declares lock after LOCK_CNT consecutive matches.
//   i_sys_clk : clock, all logic on the rising edge
//   i_sys_rst : synchronous active-high reset
//   mon       : slave side of flag_period_monitor_if (strobe in, status out)
// All outputs are registered; pulses follow the sampling edge of the strobe.
module flag_period_monitor
  import flag_period_monitor_pkg::*;
#(
  parameter int DIV      = DEF_DIV,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  flag_period_monitor_if.slave mon
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);

  state_t               r_state,   w_state_nxt;
  logic [MATCH_W-1:0]   r_match,   w_match_nxt;
  logic [CNT_W-1:0]     r_period,  w_period_nxt;
  logic                 r_vld,     w_vld_nxt;
  logic                 r_locked;
  logic                 r_err,     w_err_nxt;
  logic                 r_to,      w_to_nxt;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;

  logic [CNT_W-1:0]     w_cnt;
  logic [CNT_W-1:0]     w_interval;
  logic [MATCH_W-1:0]   w_match_inc;
  logic                 w_good;
  logic                 w_expired;

  flag_interval_cnt #(.CNT_W(CNT_W)) u_cnt (
    .i_clk (i_sys_clk),
    .i_rst (i_sys_rst),
    .i_clr (mon.flag_in),
    .o_cnt (w_cnt)
  );

  // cnt never exceeds TIMEOUT while a measurement is live, so cnt+1 fits.
  assign w_interval  = w_cnt + CNT_W'(1);
  assign w_good      = (w_interval == CNT_W'(DIV));
  assign w_match_inc = r_match + MATCH_W'(1);
  // A strobe on the timeout cycle wins; it is measured, not timed out.
  assign w_expired   = (w_cnt == CNT_W'(TIMEOUT)) && !mon.flag_in;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state   <= ST_IDLE;
      r_match   <= '0;
      r_period  <= '0;
      r_vld     <= 1'b0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_to      <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_match   <= w_match_nxt;
      r_period  <= w_period_nxt;
      r_vld     <= w_vld_nxt;
      r_locked  <= (w_state_nxt == ST_LOCKED);
      r_err     <= w_err_nxt;
      r_to      <= w_to_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_match_nxt   = r_match;
    w_period_nxt  = r_period;
    w_vld_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_to_nxt      = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    case (r_state)
      ST_IDLE: begin
        // First strobe only provides the reference edge.
        if (mon.flag_in) begin
          w_state_nxt = ST_ACQ;
          w_match_nxt = '0;
        end
      end
      ST_ACQ: begin
        if (mon.flag_in) begin
          w_period_nxt = w_interval;
          w_vld_nxt    = 1'b1;
          if (w_good) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == MATCH_W'(LOCK_CNT)) begin
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_match_nxt = '0;
          end
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
          w_match_nxt = '0;
          w_to_nxt    = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (mon.flag_in) begin
          w_period_nxt = w_interval;
          w_vld_nxt    = 1'b1;
          if (!w_good) begin
            w_state_nxt   = ST_ACQ;
            w_match_nxt   = '0;
            w_err_nxt     = 1'b1;
            w_err_cnt_nxt = sat_inc_err(r_err_cnt);
          end
        end else if (w_expired) begin
          w_state_nxt   = ST_IDLE;
          w_match_nxt   = '0;
          w_to_nxt      = 1'b1;
          w_err_cnt_nxt = sat_inc_err(r_err_cnt);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_match_nxt = '0;
      end
    endcase
  end

  assign mon.period     = r_period;
  assign mon.period_vld = r_vld;
  assign mon.locked     = r_locked;
  assign mon.err_pulse  = r_err;
  assign mon.timeout    = r_to;
  assign mon.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_flag_period_monitor.sv
module tb_flag_period_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  flag_period_monitor_if #(.CNT_W(8)) u_if ();

  flag_period_monitor #(
    .DIV(6), .LOCK_CNT(4), .TIMEOUT(24), .CNT_W(8)
  ) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .mon       (u_if)
  );

  // Drive one cycle of flag_in, then look at the registered result.
  task automatic step(input logic f);
    u_if.flag_in = f;
    @(posedge clk);
    #1;
  endtask

  // p-1 quiet cycles then a strobe: interval p. stray flags any pulse in the gap.
  task automatic gap_strobe(input int p, output logic stray);
    stray = 1'b0;
    for (int i = 0; i < p - 1; i++) begin
      step(1'b0);
      if (u_if.period_vld || u_if.err_pulse || u_if.timeout) stray = 1'b1;
    end
    step(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if ({u_if.period, u_if.period_vld, u_if.locked, u_if.err_pulse, u_if.timeout, u_if.err_cnt} !== 20'h0) begin
      $display("FAIL reset_outputs: got period=%0d vld=%0b lock=%0b err=%0b to=%0b ecnt=%0d, want all 0",
               u_if.period, u_if.period_vld, u_if.locked, u_if.err_pulse, u_if.timeout, u_if.err_cnt);
      n_fail++;
    end
  endtask

  task automatic test_acquire();
    logic stray;
    step(1'b1);
    n_run++;
    if (u_if.period_vld !== 1'b0) begin
      $display("FAIL acq_first_strobe_vld: got %0b want 0", u_if.period_vld); n_fail++;
    end
    for (int k = 2; k <= 6; k++) begin
      gap_strobe(6, stray);
      n_run++;
      if (u_if.period_vld !== 1'b1 || u_if.period !== 8'd6 || stray !== 1'b0 || u_if.err_pulse !== 1'b0) begin
        $display("FAIL acq_period_s%0d: got vld=%0b period=%0d stray=%0b err=%0b want 1/6/0/0",
                 k, u_if.period_vld, u_if.period, stray, u_if.err_pulse); n_fail++;
      end
      n_run++;
      if (u_if.locked !== (k >= 5)) begin
        $display("FAIL acq_locked_s%0d: got %0b want %0b", k, u_if.locked, (k >= 5)); n_fail++;
      end
    end
  endtask

  task automatic test_error_relock();
    logic stray;
    gap_strobe(5, stray);
    n_run++;
    if (u_if.period !== 8'd5 || u_if.err_pulse !== 1'b1 || u_if.err_cnt !== 8'd1 || u_if.locked !== 1'b0) begin
      $display("FAIL err_short_period: got period=%0d err=%0b ecnt=%0d lock=%0b want 5/1/1/0",
               u_if.period, u_if.err_pulse, u_if.err_cnt, u_if.locked); n_fail++;
    end
    for (int k = 1; k <= 4; k++) begin
      gap_strobe(6, stray);
      n_run++;
      if (u_if.locked !== (k == 4) || u_if.err_pulse !== 1'b0 || u_if.period !== 8'd6) begin
        $display("FAIL relock_g%0d: got lock=%0b err=%0b period=%0d want %0b/0/6",
                 k, u_if.locked, u_if.err_pulse, u_if.period, (k == 4)); n_fail++;
      end
    end
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b0);
      if (u_if.timeout || !u_if.locked) early = 1'b1;
    end
    n_run++;
    if (early !== 1'b0) begin
      $display("FAIL to_early: got early=%0b want 0", early); n_fail++;
    end
    step(1'b0);
    n_run++;
    if (u_if.timeout !== 1'b1 || u_if.locked !== 1'b0 || u_if.err_cnt !== 8'd2) begin
      $display("FAIL to_locked: got to=%0b lock=%0b ecnt=%0d want 1/0/2",
               u_if.timeout, u_if.locked, u_if.err_cnt); n_fail++;
    end
    step(1'b0);
    step(1'b0);
    step(1'b1);
    n_run++;
    if (u_if.period_vld !== 1'b0 || u_if.period !== 8'd6 || u_if.timeout !== 1'b0) begin
      $display("FAIL to_idle_strobe: got vld=%0b period=%0d to=%0b want 0/6/0",
               u_if.period_vld, u_if.period, u_if.timeout); n_fail++;
    end
  endtask

  task automatic test_edge_timeout();
    logic stray;
    logic early;
    gap_strobe(6, stray);
    gap_strobe(6, stray);
    n_run++;
    if (u_if.period_vld !== 1'b1 || u_if.locked !== 1'b0) begin
      $display("FAIL edge_pre_match: got vld=%0b lock=%0b want 1/0", u_if.period_vld, u_if.locked); n_fail++;
    end
    gap_strobe(25, early);
    n_run++;
    if (u_if.period !== 8'd25 || u_if.period_vld !== 1'b1 || u_if.timeout !== 1'b0 ||
        early !== 1'b0 || u_if.err_pulse !== 1'b0 || u_if.err_cnt !== 8'd2) begin
      $display("FAIL edge_strobe_at_timeout: got period=%0d vld=%0b to=%0b stray=%0b err=%0b ecnt=%0d want 25/1/0/0/0/2",
               u_if.period, u_if.period_vld, u_if.timeout, early, u_if.err_pulse, u_if.err_cnt); n_fail++;
    end
    for (int k = 1; k <= 4; k++) begin
      gap_strobe(6, stray);
      n_run++;
      if (u_if.period_vld !== 1'b1 || u_if.locked !== (k == 4)) begin
        $display("FAIL edge_match_cleared_g%0d: got vld=%0b lock=%0b want 1/%0b",
                 k, u_if.period_vld, u_if.locked, (k == 4)); n_fail++;
      end
    end
  endtask

  task automatic test_alternating();
    logic stray;
    logic bad;
    int   p;
    do_reset();
    step(1'b1);
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      p = (k % 2 == 0) ? 6 : 7;
      gap_strobe(p, stray);
      n_run++;
      if (u_if.locked !== 1'b0 || u_if.err_pulse !== 1'b0 || u_if.period !== 8'(p)) begin
        $display("FAIL alt_k%0d: got lock=%0b err=%0b period=%0d want 0/0/%0d",
                 k, u_if.locked, u_if.err_pulse, u_if.period, p); n_fail++;
      end
    end
    for (int k = 0; k < 4; k++) gap_strobe(6, stray);
    n_run++;
    if (u_if.locked !== 1'b1) begin
      $display("FAIL alt_then_lock: got %0b want 1", u_if.locked); n_fail++;
    end
    step(1'b0);
    rst = 1'b1;
    step(1'b1);
    n_run++;
    if ({u_if.period, u_if.period_vld, u_if.locked, u_if.err_pulse, u_if.timeout, u_if.err_cnt} !== 20'h0) begin
      $display("FAIL mid_lock_reset: got period=%0d vld=%0b lock=%0b err=%0b to=%0b ecnt=%0d want all 0",
               u_if.period, u_if.period_vld, u_if.locked, u_if.err_pulse, u_if.timeout, u_if.err_cnt);
      n_fail++;
    end
    rst = 1'b0;
    step(1'b0);
    step(1'b1);
    n_run++;
    if (u_if.period_vld !== 1'b0 || u_if.locked !== 1'b0) begin
      $display("FAIL post_reset_idle: got vld=%0b lock=%0b want 0/0", u_if.period_vld, u_if.locked); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic early;
    do_reset();
    step(1'b1);
    step(1'b1);
    n_run++;
    if (u_if.period_vld !== 1'b1 || u_if.period !== 8'd1 || u_if.locked !== 1'b0) begin
      $display("FAIL b2b_period: got vld=%0b period=%0d lock=%0b want 1/1/0",
               u_if.period_vld, u_if.period, u_if.locked); n_fail++;
    end
    early = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step(1'b0);
      if (u_if.timeout) early = 1'b1;
    end
    step(1'b0);
    n_run++;
    if (early !== 1'b0 || u_if.timeout !== 1'b1 || u_if.err_cnt !== 8'd0) begin
      $display("FAIL acq_timeout: got early=%0b to=%0b ecnt=%0d want 0/1/0",
               early, u_if.timeout, u_if.err_cnt); n_fail++;
    end
  endtask

  task automatic test_saturate();
    logic stray;
    do_reset();
    step(1'b1);
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) gap_strobe(6, stray);
      gap_strobe(5, stray);
      if (i == 0 || i == 253 || i == 254 || i == 299) begin
        n_run++;
        if (u_if.err_pulse !== 1'b1 || u_if.err_cnt !== 8'((i + 1 > 255) ? 255 : i + 1)) begin
          $display("FAIL sat_err%0d: got err=%0b ecnt=%0d want 1/%0d",
                   i + 1, u_if.err_pulse, u_if.err_cnt, (i + 1 > 255) ? 255 : i + 1); n_fail++;
        end
      end
    end
  endtask

  initial begin
    u_if.flag_in = 1'b0;
    test_reset();
    test_acquire();
    test_error_relock();
    test_timeout();
    test_edge_timeout();
    test_alternating();
    test_back_to_back();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
